// File: rtl/pot_mult_sequencer.sv
// Sequences a shared shift-add power-of-two multiplier to build a full A_W x B_W unsigned product.
// Optional POT_MULT_CSD_EN: replaces long runs of ones with a single (a<<(k+1))-(a<<i) op.
module pot_mult_sequencer #(
    parameter int unsigned A_W = 16,
    parameter int unsigned N   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [A_W-1:0]       in_a,
    input  logic [(1<<N)-1:0]    in_b,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [2*A_W-1:0]     out_c,
    output logic                 busy,
    output logic [A_W-1:0]       mul_a,
    output logic [N-1:0]         mul_b_i,
    output logic [N-1:0]         mul_b_j,
    output logic                 mul_one_term,
    output logic                 mul_b_sign,
    output logic                 mul_vld,
    input  logic [2*A_W-1:0]     mul_c,
    input  logic                 mul_result_vld
);

    localparam int unsigned B_W = 1 << N;
    localparam int unsigned P_W = 2 * A_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]     state;
    logic [1:0]     state_nxt;
    logic [A_W-1:0] a_q;
    logic [A_W-1:0] a_nxt;
    logic [B_W-1:0] rem;
    logic [B_W-1:0] rem_nxt;
    logic [P_W-1:0] acc;
    logic [P_W-1:0] acc_nxt;

    logic [B_W-1:0] low_m;
    logic [B_W-1:0] rest_m;
    logic [B_W-1:0] clr_m;
    logic [B_W-1:0] rem_after;
    logic [N-1:0]   idx_i;
    logic [N-1:0]   idx_j;
    logic [N-1:0]   op_b_i;
    logic [N-1:0]   op_b_j;
    logic           op_one_term;
`ifdef POT_MULT_CSD_EN
    logic [B_W-1:0] run_sum;
    logic [B_W-1:0] run_m;
    logic [N-1:0]   idx_k;
    logic           op_sign;
`endif

    function automatic logic [N-1:0] lowest_idx(input logic [B_W-1:0] v);
        logic [N-1:0] idx;
        idx = '0;
        for (int p = B_W - 1; p >= 0; p--) begin
            if (v[p]) idx = N'(p);
        end
        return idx;
    endfunction

`ifdef POT_MULT_CSD_EN
    function automatic logic [N-1:0] highest_idx(input logic [B_W-1:0] v);
        logic [N-1:0] idx;
        idx = '0;
        for (int p = 0; p < B_W; p++) begin
            if (v[p]) idx = N'(p);
        end
        return idx;
    endfunction
`endif

    // Op decode from the remaining multiplier bits: pair the two lowest set bits.
    always_comb begin
        low_m       = rem & (~rem + B_W'(1));
        rest_m      = rem & ~low_m;
        idx_i       = lowest_idx(rem);
        idx_j       = lowest_idx(rest_m);
        op_b_i      = idx_i;
        op_b_j      = '0;
        op_one_term = 1'b1;
        clr_m       = low_m;
        if (rest_m != '0) begin
            op_b_i      = idx_j;
            op_b_j      = idx_i;
            op_one_term = 1'b0;
            clr_m       = low_m | (rest_m & (~rest_m + B_W'(1)));
        end
`ifdef POT_MULT_CSD_EN
        // Lowest run of ones i..k: adding its lowest bit ripples a carry through it.
        op_sign = 1'b0;
        run_sum = rem + low_m;
        run_m   = (rem ^ run_sum) & rem;
        idx_k   = highest_idx(run_m);
        if (!run_m[B_W-1] && ((idx_k - idx_i) >= N'(2))) begin
            op_b_i      = idx_k + N'(1);
            op_b_j      = idx_i;
            op_one_term = 1'b0;
            op_sign     = 1'b1;
            clr_m       = run_m;
        end
`endif
        rem_after = rem & ~clr_m;
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        rem_nxt   = rem;
        acc_nxt   = acc;
        case (state)
            S_IDLE: begin
                if (in_vld && in_rdy) begin
                    a_nxt     = in_a;
                    rem_nxt   = in_b;
                    acc_nxt   = '0;
                    state_nxt = (in_b != '0) ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                if (mul_result_vld) begin
                    acc_nxt = acc + mul_c;
                    rem_nxt = rem_after;
                    if (rem_after == '0) state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_rdy) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            a_q   <= '0;
            rem   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            a_q   <= a_nxt;
            rem   <= rem_nxt;
            acc   <= acc_nxt;
        end
    end

    // Handshake flags are pure state decodes; op fields are forced to 0 outside ISSUE.
    assign in_rdy       = (state == S_IDLE) && !rst;
    assign busy         = (state == S_ISSUE) || (state == S_DONE);
    assign out_vld      = (state == S_DONE);
    assign out_c        = acc;
    assign mul_vld      = (state == S_ISSUE);
    assign mul_a        = a_q;
    assign mul_b_i      = mul_vld ? op_b_i : '0;
    assign mul_b_j      = mul_vld ? op_b_j : '0;
    assign mul_one_term = mul_vld && op_one_term;
`ifdef POT_MULT_CSD_EN
    assign mul_b_sign   = mul_vld && op_sign;
`else
    assign mul_b_sign   = 1'b0;
`endif

endmodule

// File: tb/tb_pot_mult_sequencer.sv
// Bench for pot_mult_sequencer with a behavioural shift-add multiplier and a result scoreboard.
module tb_pot_mult_sequencer;

    logic        clk;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] out_c;
    logic        busy;
    logic [15:0] mul_a;
    logic [3:0]  mul_b_i;
    logic [3:0]  mul_b_j;
    logic        mul_one_term;
    logic        mul_b_sign;
    logic        mul_vld;
    logic [31:0] mul_c;
    logic        mul_result_vld;
    logic        stall;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] c;
        int          ops_p;
        logic [3:0]  bi_p;
        logic [3:0]  bj_p;
        logic        ot_p;
        int          ops_c;
        logic [3:0]  bi_c;
        logic [3:0]  bj_c;
        logic        ot_c;
        logic        sg_c;
    } vec_t;

    vec_t vecs[9];

    pot_mult_sequencer #(.A_W(16), .N(4)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_a(in_a), .in_b(in_b),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_c(out_c), .busy(busy),
        .mul_a(mul_a), .mul_b_i(mul_b_i), .mul_b_j(mul_b_j),
        .mul_one_term(mul_one_term), .mul_b_sign(mul_b_sign), .mul_vld(mul_vld),
        .mul_c(mul_c), .mul_result_vld(mul_result_vld)
    );

    // Reference combinational multiplier with an optional result stall.
    logic [31:0] sh_i;
    logic [31:0] sh_j;
    assign sh_i = {16'h0, mul_a} << mul_b_i;
    assign sh_j = {16'h0, mul_a} << mul_b_j;
    assign mul_c = mul_one_term ? sh_i : (mul_b_sign ? (sh_i - sh_j) : (sh_i + sh_j));
    assign mul_result_vld = mul_vld && !stall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_req(input vec_t v, input int stall_cycles, input int hold_cycles);
        int          cyc;
        int          ops;
        int          e_ops;
        logic [3:0]  e_bi;
        logic [3:0]  e_bj;
        logic        e_ot;
        logic        e_sg;
        logic [31:0] exp_c;
        logic        got;
`ifdef POT_MULT_CSD_EN
        e_ops = v.ops_c; e_bi = v.bi_c; e_bj = v.bj_c; e_ot = v.ot_c; e_sg = v.sg_c;
`else
        e_ops = v.ops_p; e_bi = v.bi_p; e_bj = v.bj_p; e_ot = v.ot_p; e_sg = 1'b0;
`endif
        cyc = 0;
        while (!in_rdy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("in_rdy_before_req", 64'(in_rdy), 64'(1));
        ops     = 0;
        stall   = 1'b0;
        out_rdy = (hold_cycles == 0);
        in_a    = v.a;
        in_b    = v.b;
        in_vld  = 1'b1;
        sb.push_back(v.c);
        @(negedge clk);
        in_vld = 1'b0;
        cyc    = 1;
        got    = 1'b0;
        while (cyc < 200 && !got) begin
            if (out_vld) begin
                got = 1'b1;
            end else begin
                if (e_ops > 0 && cyc <= 1 + stall_cycles) begin
                    check("first_op_vld", 64'(mul_vld), 64'(1));
                    check("first_op_a", 64'(mul_a), 64'(v.a));
                    check("first_op_b_i", 64'(mul_b_i), 64'(e_bi));
                    check("first_op_b_j", 64'(mul_b_j), 64'(e_bj));
                    check("first_op_one_term", 64'(mul_one_term), 64'(e_ot));
                    check("first_op_sign", 64'(mul_b_sign), 64'(e_sg));
                end
                stall = (cyc < 1 + stall_cycles) ? 1'b1 : 1'b0;
                if (mul_vld && !stall) ops++;
                @(negedge clk);
                cyc++;
            end
        end
        check("out_latency", 64'(got ? cyc : -1), 64'(e_ops + stall_cycles + 1));
        check("op_count", 64'(ops), 64'(e_ops));
        exp_c = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        for (int h = 0; h < hold_cycles; h++) begin
            check("hold_out_vld", 64'(out_vld), 64'(1));
            check("hold_out_c", 64'(out_c), 64'(exp_c));
            check("hold_in_rdy", 64'(in_rdy), 64'(0));
            @(negedge clk);
        end
        out_rdy = 1'b1;
        check("out_c", 64'(out_c), 64'(exp_c));
        check("busy_done", 64'(busy), 64'(1));
        check("in_rdy_done", 64'(in_rdy), 64'(0));
        @(negedge clk);
        check("idle_out_vld", 64'(out_vld), 64'(0));
        check("idle_in_rdy", 64'(in_rdy), 64'(1));
    endtask

    initial begin
        vecs[0] = '{16'h0003, 16'h0005, 32'd15,         1, 4'd2,  4'd0, 1'b0, 1, 4'd2,  4'd0, 1'b0, 1'b0};
        vecs[1] = '{16'h0009, 16'h0000, 32'd0,          0, 4'd0,  4'd0, 1'b0, 0, 4'd0,  4'd0, 1'b0, 1'b0};
        vecs[2] = '{16'h0009, 16'h0001, 32'd9,          1, 4'd0,  4'd0, 1'b1, 1, 4'd0,  4'd0, 1'b1, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001,   8, 4'd1,  4'd0, 1'b0, 8, 4'd1,  4'd0, 1'b0, 1'b0};
        vecs[4] = '{16'h0007, 16'h00F0, 32'd1680,       2, 4'd5,  4'd4, 1'b0, 1, 4'd8,  4'd4, 1'b0, 1'b1};
        vecs[5] = '{16'h1234, 16'h8000, 32'h091A0000,   1, 4'd15, 4'd0, 1'b1, 1, 4'd15, 4'd0, 1'b1, 1'b0};
        vecs[6] = '{16'hABCD, 16'h0707, 32'd79121819,   3, 4'd1,  4'd0, 1'b0, 2, 4'd3,  4'd0, 1'b0, 1'b1};
        vecs[7] = '{16'h0001, 16'h5555, 32'd21845,      4, 4'd2,  4'd0, 1'b0, 4, 4'd2,  4'd0, 1'b0, 1'b0};
        vecs[8] = '{16'hFFFF, 16'h7FFF, 32'd2147385345, 8, 4'd1,  4'd0, 1'b0, 1, 4'd15, 4'd0, 1'b0, 1'b1};

        rst     = 1'b1;
        in_vld  = 1'b0;
        in_a    = '0;
        in_b    = '0;
        out_rdy = 1'b1;
        stall   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_rdy", 64'(in_rdy), 64'(0));
        check("rst_out_vld", 64'(out_vld), 64'(0));
        check("rst_out_c", 64'(out_c), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_mul_vld", 64'(mul_vld), 64'(0));
        check("rst_mul_fields", 64'({mul_a, mul_b_i, mul_b_j, mul_one_term, mul_b_sign}), 64'(0));
        rst = 1'b0;
        #1;
        check("post_rst_in_rdy", 64'(in_rdy), 64'(1));

        for (int k = 0; k < 9; k++) run_req(vecs[k], 0, 0);

        // Multiplier stall: op held with stable fields until result_vld.
        run_req(vecs[0], 3, 0);
        // Consumer back-pressure in DONE.
        run_req(vecs[4], 0, 5);

        // Reset in the middle of a multi-op request.
        @(negedge clk);
        in_a   = 16'h0001;
        in_b   = 16'h5555;
        in_vld = 1'b1;
        sb.push_back(32'd21845);
        @(negedge clk);
        in_vld = 1'b0;
        @(negedge clk);
        check("mid_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_mul_vld", 64'(mul_vld), 64'(0));
        check("mid_rst_out_vld", 64'(out_vld), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("after_rst_in_rdy", 64'(in_rdy), 64'(1));
        check("after_rst_mul_vld", 64'(mul_vld), 64'(0));
        check("after_rst_out_vld", 64'(out_vld), 64'(0));
        check("after_rst_out_c", 64'(out_c), 64'(0));
        run_req(vecs[6], 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
